// File: rtl/uart_frame_packetizer.sv
// rtl/uart_frame_packetizer.sv - groups FIFO bytes into length-prefixed checksummed UART packets
module uart_frame_packetizer #(
  parameter int          PayloadMax    = 64,
  parameter int          TimeoutCycles = 4096,
  parameter logic [7:0]  SyncByte0     = 8'hA5,
  parameter logic [7:0]  SyncByte1     = 8'h5A
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       i_empty,
  input  logic [7:0] i_byte,
  output logic       o_fetch,
  input  logic       i_frame_sync,
  input  logic       i_uart_ready,
  output logic [7:0] o_byte,
  output logic       o_valid,
  output logic       o_busy,
  output logic [5:0] o_seq
);

  localparam logic [2:0] S_FILL    = 3'd0;
  localparam logic [2:0] S_HDR0    = 3'd1;
  localparam logic [2:0] S_HDR1    = 3'd2;
  localparam logic [2:0] S_TYPESEQ = 3'd3;
  localparam logic [2:0] S_LEN     = 3'd4;
  localparam logic [2:0] S_PAYLOAD = 3'd5;
  localparam logic [2:0] S_CSUM    = 3'd6;

  localparam int         AW   = (PayloadMax > 1) ? $clog2(PayloadMax) : 1;
  localparam int         IW   = $clog2(TimeoutCycles + 1);
  localparam logic [7:0] PMAX = 8'(PayloadMax);
  localparam logic [IW-1:0] TMO = IW'(TimeoutCycles);

  logic [2:0]    state;
  logic [7:0]    count;
  logic [IW-1:0] idle;
  logic [7:0]    idx;
  logic [7:0]    csum;
  logic [5:0]    seq;
  logic          sync_pending;
  logic          is_sync;
  logic [7:0]    buffer [0:(1<<AW)-1];

  logic flush_data;
  logic flush_sync;
  logic xfer;

  // Flush decisions; buffered data always wins over a pending sync packet
  always_comb begin
    flush_data = (count == PMAX) || (idle == TMO) || (sync_pending && (count != 8'd0));
    flush_sync = sync_pending && (count == 8'd0);
    o_fetch    = !RST && (state == S_FILL) && !i_empty && (count < PMAX)
                 && !flush_data && !flush_sync;
    o_valid    = (state != S_FILL);
    o_busy     = (state != S_FILL);
    o_seq      = seq;
    xfer       = o_valid && i_uart_ready;
  end

  // Byte presented to the UART for the current packet field
  always_comb begin
    o_byte = 8'h00;
    case (state)
      S_HDR0:    o_byte = SyncByte0;
      S_HDR1:    o_byte = SyncByte1;
      S_TYPESEQ: o_byte = {(is_sync ? 2'b01 : 2'b00), seq};
      S_LEN:     o_byte = is_sync ? 8'h00 : count;
      S_PAYLOAD: o_byte = buffer[idx[AW-1:0]];
      S_CSUM:    o_byte = csum;
      default:   o_byte = 8'h00;
    endcase
  end

  // Payload storage; written only while filling
  always_ff @(posedge CLK) begin
    if (o_fetch) buffer[count[AW-1:0]] <= i_byte;
  end

  // Packet FSM, fill/idle counters, sequence number and sync bookkeeping
  always_ff @(posedge CLK) begin
    if (RST) begin
      state        <= S_FILL;
      count        <= 8'd0;
      idle         <= '0;
      idx          <= 8'd0;
      csum         <= 8'd0;
      seq          <= 6'd0;
      sync_pending <= 1'b0;
      is_sync      <= 1'b0;
    end else begin
      // A new pulse on the clearing edge must survive, so set has priority
      if (i_frame_sync)
        sync_pending <= 1'b1;
      else if ((state == S_CSUM) && xfer && is_sync)
        sync_pending <= 1'b0;

      case (state)
        S_FILL: begin
          if (flush_data || flush_sync) begin
            state   <= S_HDR0;
            is_sync <= !flush_data;
            idle    <= '0;
          end else if (o_fetch) begin
            count <= count + 8'd1;
            idle  <= '0;
          end else if (i_empty && (count != 8'd0)) begin
            idle <= idle + IW'(1);
          end
        end
        S_HDR0: begin
          csum <= 8'd0;
          if (xfer) state <= S_HDR1;
        end
        S_HDR1: begin
          if (xfer) state <= S_TYPESEQ;
        end
        S_TYPESEQ: begin
          if (xfer) begin
            csum  <= csum + o_byte;
            state <= S_LEN;
          end
        end
        S_LEN: begin
          if (xfer) begin
            csum  <= csum + o_byte;
            idx   <= 8'd0;
            state <= is_sync ? S_CSUM : S_PAYLOAD;
          end
        end
        S_PAYLOAD: begin
          if (xfer) begin
            csum <= csum + o_byte;
            if (idx == count - 8'd1) state <= S_CSUM;
            else                     idx   <= idx + 8'd1;
          end
        end
        S_CSUM: begin
          if (xfer) begin
            seq   <= seq + 6'd1;
            count <= 8'd0;
            idle  <= '0;
            state <= S_FILL;
          end
        end
        default: state <= S_FILL;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_frame_packetizer.sv
// tb/tb_uart_frame_packetizer.sv - directed self-checking bench for uart_frame_packetizer
module tb_uart_frame_packetizer;

  logic       CLK = 1'b0;
  logic       RST;
  logic       i_empty;
  logic [7:0] i_byte;
  logic       o_fetch;
  logic       i_frame_sync;
  logic       i_uart_ready;
  logic [7:0] o_byte;
  logic       o_valid;
  logic       o_busy;
  logic [5:0] o_seq;

  int checks   = 0;
  int failures = 0;

  logic [7:0] fifo_mem [0:63];
  int rd = 0;
  int wr = 0;

  logic [7:0] cap    [0:1023];
  int         capcyc [0:1023];
  int         ncap = 0;
  int         cyc  = 0;

  logic [7:0] exp1 [0:8]  = '{8'hA5, 8'h5A, 8'h00, 8'h04, 8'h01, 8'h02, 8'h03, 8'h04, 8'h0E};
  logic [7:0] exp2 [0:6]  = '{8'hA5, 8'h5A, 8'h01, 8'h02, 8'h10, 8'h20, 8'h33};
  logic [7:0] exp4 [0:11] = '{8'hA5, 8'h5A, 8'h06, 8'h03, 8'h07, 8'h08, 8'h09, 8'h21,
                              8'hA5, 8'h5A, 8'h47, 8'h00};
  logic [7:0] exp5 [0:8]  = '{8'hA5, 8'h5A, 8'h08, 8'h04, 8'h11, 8'h22, 8'h33, 8'h44, 8'hB6};

  uart_frame_packetizer #(
    .PayloadMax   (4),
    .TimeoutCycles(16),
    .SyncByte0    (8'hA5),
    .SyncByte1    (8'h5A)
  ) dut (
    .CLK         (CLK),
    .RST         (RST),
    .i_empty     (i_empty),
    .i_byte      (i_byte),
    .o_fetch     (o_fetch),
    .i_frame_sync(i_frame_sync),
    .i_uart_ready(i_uart_ready),
    .o_byte      (o_byte),
    .o_valid     (o_valid),
    .o_busy      (o_busy),
    .o_seq       (o_seq)
  );

  always #5 CLK = ~CLK;

  assign i_empty = (rd == wr);
  assign i_byte  = fifo_mem[rd[5:0]];

  always @(posedge CLK) begin
    cyc <= cyc + 1;
    if (o_fetch) rd <= rd + 1;
    if (o_valid && i_uart_ready && ncap < 1024) begin
      cap[ncap]    <= o_byte;
      capcyc[ncap] <= cyc;
      ncap         <= ncap + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [7:0] b);
    fifo_mem[wr[5:0]] = b;
    wr++;
  endtask

  task automatic pulse_sync();
    i_frame_sync = 1'b1;
    @(negedge CLK);
    i_frame_sync = 1'b0;
  endtask

  task automatic wait_caps(input int n, input string tag);
    int t = 0;
    while (ncap < n && t < 300) begin
      @(negedge CLK);
      t++;
    end
    chk(tag, 32'(ncap >= n), 32'd1);
  endtask

  task automatic wait_idle(input string tag);
    int t = 0;
    while (o_busy && t < 300) begin
      @(negedge CLK);
      t++;
    end
    chk(tag, 32'(o_busy), 32'd0);
  endtask

  initial begin
    int  base;
    int  c0;
    logic stable;

    RST = 1'b1;
    i_frame_sync = 1'b0;
    i_uart_ready = 1'b1;
    push(8'h01); push(8'h02); push(8'h03); push(8'h04);
    repeat (3) @(negedge CLK);
    chk("rst_fetch", 32'(o_fetch), 32'd0);
    chk("rst_valid", 32'(o_valid), 32'd0);
    chk("rst_byte",  32'(o_byte),  32'h00);
    chk("rst_busy",  32'(o_busy),  32'd0);
    chk("rst_seq",   32'(o_seq),   32'd0);

    // Full payload flush
    base = ncap;
    RST = 1'b0;
    wait_caps(base + 9, "t1_timeout");
    for (int i = 0; i < 9; i++) chk($sformatf("t1_b%0d", i), 32'(cap[base+i]), 32'(exp1[i]));
    chk("t1_consecutive", 32'(capcyc[base+8] - capcyc[base]), 32'd8);
    wait_idle("t1_idle");
    chk("t1_seq", 32'(o_seq), 32'd1);

    // Idle-timeout flush of a partial payload
    base = ncap;
    c0 = cyc;
    push(8'h10); push(8'h20);
    wait_caps(base + 7, "t2_timeout");
    for (int i = 0; i < 7; i++) chk($sformatf("t2_b%0d", i), 32'(cap[base+i]), 32'(exp2[i]));
    chk("t2_first_cycle", 32'(capcyc[base] - c0), 32'd19);
    wait_idle("t2_idle");

    // Sync packets with empty buffer: seq 2..5
    base = ncap;
    for (int k = 0; k < 4; k++) begin
      pulse_sync();
      wait_caps(base + 5 * (k + 1), "t3_timeout");
      wait_idle("t3_idle");
    end
    chk("t3_s5_hdr0", 32'(cap[base+15]), 32'hA5);
    chk("t3_s5_hdr1", 32'(cap[base+16]), 32'h5A);
    chk("t3_s5_ts",   32'(cap[base+17]), 32'h45);
    chk("t3_s5_len",  32'(cap[base+18]), 32'h00);
    chk("t3_s5_csum", 32'(cap[base+19]), 32'h45);
    repeat (6) @(negedge CLK);
    chk("t3_no_extra", 32'(ncap - base), 32'd20);
    chk("t3_busy_clear", 32'(o_busy), 32'd0);

    // Data then exactly one sync packet after double pulse
    base = ncap;
    push(8'h07); push(8'h08); push(8'h09);
    repeat (5) @(negedge CLK);
    pulse_sync();
    @(negedge CLK);
    pulse_sync();
    wait_caps(base + 13, "t4_timeout");
    for (int i = 0; i < 12; i++) chk($sformatf("t4_b%0d", i), 32'(cap[base+i]), 32'(exp4[i]));
    chk("t4_sync_csum", 32'(cap[base+12]), 32'h47);
    wait_idle("t4_idle");
    repeat (8) @(negedge CLK);
    chk("t4_count", 32'(ncap - base), 32'd13);
    chk("t4_seq", 32'(o_seq), 32'd8);

    // Back-pressure on payload index 2
    base = ncap;
    push(8'h11); push(8'h22); push(8'h33); push(8'h44);
    wait_caps(base + 6, "t5_reach");
    i_uart_ready = 1'b0;
    stable = 1'b1;
    for (int i = 0; i < 7; i++) begin
      if (!(o_valid === 1'b1 && o_byte === 8'h33)) stable = 1'b0;
      @(negedge CLK);
    end
    chk("t5_stable", 32'(stable), 32'd1);
    chk("t5_held_count", 32'(ncap - base), 32'd6);
    i_uart_ready = 1'b1;
    wait_caps(base + 9, "t5_timeout");
    for (int i = 0; i < 9; i++) chk($sformatf("t5_b%0d", i), 32'(cap[base+i]), 32'(exp5[i]));
    wait_idle("t5_idle");

    // Reset during LEN aborts the packet
    base = ncap;
    push(8'h55); push(8'h66); push(8'h77); push(8'h88);
    wait_caps(base + 3, "t6_reach");
    RST = 1'b1;
    @(negedge CLK);
    chk("t6_valid", 32'(o_valid), 32'd0);
    chk("t6_seq",   32'(o_seq),   32'd0);
    chk("t6_busy",  32'(o_busy),  32'd0);
    RST = 1'b0;
    @(negedge CLK);

    // 64 sync packets from seq 0; the first also proves the buffer was cleared
    base = ncap;
    for (int k = 0; k < 64; k++) begin
      pulse_sync();
      wait_caps(base + 5 * (k + 1), "t7_timeout");
      chk($sformatf("t7_ts%0d", k), 32'(cap[base+5*k+2]), 32'({2'b01, 6'(k)}));
      wait_idle("t7_idle");
    end
    chk("t7_first_len",  32'(cap[base+3]), 32'h00);
    chk("t7_first_csum", 32'(cap[base+4]), 32'h40);
    chk("t7_wrap", 32'(o_seq), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
